// File: rtl/cmd_feeder.sv
// Purpose: buffers host command words in a FIFO and replays each packet on instruct with fixed pacing.
// Latency: a read header pushed into an idle, empty block appears on instruct 2 cycles after the push edge.
// Backpressure: in_ready drops only when the FIFO is full; a packet starts only if it can run without stalling.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   in_data/in_valid    host command words; transfer on in_valid & in_ready
//   in_ready            FIFO has room
//   instruct            registered word to the controller, 0 when idle
//   rd_window           high while the controller streams read data
//   busy                FSM is not idle
//   pkt_done            one-cycle pulse as the block returns to idle after a packet's gap
module cmd_feeder #(
    parameter int DEPTH = 16,
    parameter int GAP   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] instruct,
    output logic        rd_window,
    output logic        busy,
    output logic        pkt_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        RDWAIT,
        GAP_ST
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic [31:0]   head;

    assign in_ready = (count != CW'(DEPTH));
    assign push     = in_valid & in_ready;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Header decode: number of data words (write) or readout words (read)
    // ------------------------------------------------------------------
    function automatic logic [3:0] words_for_sel(input logic [3:0] sel);
        logic [3:0] n;
        case (sel)
            4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd9: n = 4'd4;
            4'd5, 4'd6:                         n = 4'd8;
            4'd12, 4'd13, 4'd14:                n = 4'd5;
            default:                            n = 4'd1;
        endcase
        return n;
    endfunction

    logic [3:0]    head_n;
    logic [CW-1:0] need_words;

    assign head_n     = words_for_sel(head[3:0]);
    assign need_words = CW'(head_n) + CW'(1);

    // ------------------------------------------------------------------
    // Packet FSM
    // ------------------------------------------------------------------
    state_t        state, state_d;
    logic [3:0]    cnt, cnt_d;
    logic [3:0]    n_q, n_d;
    logic [GW-1:0] gap_cnt, gap_cnt_d;
    logic [31:0]   instruct_d;
    logic          rd_window_d;
    logic          pkt_done_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            n_q       <= '0;
            gap_cnt   <= '0;
            instruct  <= '0;
            rd_window <= 1'b0;
            pkt_done  <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            n_q       <= n_d;
            gap_cnt   <= gap_cnt_d;
            instruct  <= instruct_d;
            rd_window <= rd_window_d;
            pkt_done  <= pkt_done_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        n_d         = n_q;
        gap_cnt_d   = gap_cnt;
        instruct_d  = '0;
        rd_window_d = 1'b0;
        pkt_done_d  = 1'b0;
        pop         = 1'b0;

        case (state)
            IDLE: begin
                // A write only starts once its header and every data word
                // are buffered, so DATA can pop one word per cycle.
                if (count != '0 && (!head[31] || count >= need_words)) begin
                    state_d = HDR;
                end
            end
            HDR: begin
                instruct_d = head;
                pop        = 1'b1;
                n_d        = head_n;
                cnt_d      = '0;
                gap_cnt_d  = '0;
                state_d    = head[31] ? DATA : RDWAIT;
            end
            DATA: begin
                instruct_d = head;
                pop        = 1'b1;
                cnt_d      = cnt + 4'd1;
                if (cnt == n_q - 4'd1) begin
                    state_d = GAP_ST;
                end
            end
            RDWAIT: begin
                // cnt runs 0..N, giving N+1 readout cycles.
                rd_window_d = 1'b1;
                cnt_d       = cnt + 4'd1;
                if (cnt == n_q) begin
                    state_d = GAP_ST;
                end
            end
            GAP_ST: begin
                gap_cnt_d = gap_cnt + 1'b1;
                if (gap_cnt == GW'(GAP - 1)) begin
                    state_d    = IDLE;
                    pkt_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
